// File: rtl/y86_pkg.sv
// Y86-64 shared constants: instruction codes, status codes and the no-register id.
// Also holds the exception-status test used by the pipeline control logic.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SBUB = 3'd0;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    function automatic logic is_exc(input logic [2:0] stat);
        return (stat == SHLT) || (stat == SADR) || (stat == SINS);
    endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational hazard detection and the pipeline-register controls used while running.
// The top overrides these controls once the core has halted.
module pipe_hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_cnd,
    input  logic [3:0] M_icode,
    input  logic [2:0] m_stat,
    input  logic [2:0] W_stat,
    output logic       load_use,
    output logic       ret_haz,
    output logic       mispred,
    output logic       run_f_stall,
    output logic       run_d_stall,
    output logic       run_d_bubble,
    output logic       run_e_bubble,
    output logic       run_m_bubble,
    output logic       run_w_stall
);

    always_comb begin
        load_use = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        ret_haz  = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
        mispred  = (E_icode == IJXX) && !e_cnd;
    end

    // A load/use stall already holds D, so the ret bubble must not clobber it.
    always_comb begin
        run_f_stall  = load_use || ret_haz;
        run_d_stall  = load_use;
        run_d_bubble = mispred || (ret_haz && !load_use);
        run_e_bubble = mispred || load_use;
        run_m_bubble = is_exc(m_stat) || is_exc(W_stat);
        run_w_stall  = is_exc(W_stat);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 PIPE control: hazard stall/bubble outputs, architectural CC register,
// RUN/HALTED state machine and saturating performance counters.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_RUN     | normal operation, hazard controls drive the pipe
//   ST_HALTED  | W-stage exception seen; F/D/W held, no bubbles, exit on reset
module pipe_hazard_ctrl
    import y86_pkg::*;
#(
    parameter int         CNT_W  = 32,
    parameter logic [2:0] CC_RST = 3'b100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    input  logic [2:0]       alu_cf,
    output logic [2:0]       cc,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             halted,
    output logic [2:0]       halt_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    localparam logic ST_RUN    = 1'b0;
    localparam logic ST_HALTED = 1'b1;

    logic state;
    logic load_use, ret_haz, mispred;
    logic run_f_stall, run_d_stall, run_d_bubble, run_e_bubble, run_m_bubble, run_w_stall;
    logic running;
    logic cc_en;

    pipe_hazard_detect u_detect (
        .D_icode      (D_icode),
        .d_srcA       (d_srcA),
        .d_srcB       (d_srcB),
        .E_icode      (E_icode),
        .E_dstM       (E_dstM),
        .e_cnd        (e_cnd),
        .M_icode      (M_icode),
        .m_stat       (m_stat),
        .W_stat       (W_stat),
        .load_use     (load_use),
        .ret_haz      (ret_haz),
        .mispred      (mispred),
        .run_f_stall  (run_f_stall),
        .run_d_stall  (run_d_stall),
        .run_d_bubble (run_d_bubble),
        .run_e_bubble (run_e_bubble),
        .run_m_bubble (run_m_bubble),
        .run_w_stall  (run_w_stall)
    );

    assign running = (state == ST_RUN);
    assign halted  = (state == ST_HALTED);

    always_comb begin
        F_stall  = run_f_stall;
        D_stall  = run_d_stall;
        D_bubble = run_d_bubble;
        E_bubble = run_e_bubble;
        M_bubble = run_m_bubble;
        W_stall  = run_w_stall;
        if (!running) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            D_bubble = 1'b0;
            E_bubble = 1'b0;
            M_bubble = 1'b0;
            W_stall  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            halt_stat <= SAOK;
        end else if (running && is_exc(W_stat)) begin
            state     <= ST_HALTED;
            halt_stat <= W_stat;
        end
    end

    // An OPq behind a faulting instruction must not update the flags.
    assign cc_en = running && (E_icode == IOPQ) && !is_exc(m_stat) && !is_exc(W_stat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc <= CC_RST;
        end else if (cc_en) begin
            cc <= alu_cf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            lu_cnt  <= '0;
            mp_cnt  <= '0;
            ret_cnt <= '0;
        end else if (running) begin
            if (cyc_cnt != '1)
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (load_use && (lu_cnt != '1))
                lu_cnt <= lu_cnt + CNT_W'(1);
            if (mispred && (mp_cnt != '1))
                mp_cnt <= mp_cnt + CNT_W'(1);
            if (ret_haz && !load_use && (ret_cnt != '1))
                ret_cnt <= ret_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with 4-bit counters so saturation is reachable.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic       e_cnd;
    logic [2:0] m_stat, W_stat, alu_cf;
    logic [2:0] cc, halt_stat;
    logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
    logic [3:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(4), .CC_RST(3'b100)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat), .alu_cf(alu_cf),
        .cc(cc), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .halted(halted), .halt_stat(halt_stat),
        .cyc_cnt(cyc_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
    );

    task automatic idle();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
        e_cnd = 1'b1; m_stat = 3'd1; W_stat = 3'd1; alu_cf = 3'b000;
    endtask

    // Leaves time at posedge+1 with reset released; the next posedge is the first RUN edge.
    task automatic do_reset();
        @(posedge clk); #1;
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (cc !== 3'b100) begin errors++; $display("FAIL reset_cc got=%b exp=100", cc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (halt_stat !== 3'd1) begin errors++; $display("FAIL reset_halt_stat got=%0d exp=1", halt_stat); end
        checks++; if ({cyc_cnt, lu_cnt, mp_cnt, ret_cnt} !== 16'h0) begin errors++;
            $display("FAIL reset_cnts got=%h exp=0000", {cyc_cnt, lu_cnt, mp_cnt, ret_cnt}); end
        checks++; if ({F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall} !== 6'b0) begin errors++;
            $display("FAIL reset_ctrl got=%b exp=000000", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}); end
    endtask

    task automatic test_load_use();
        do_reset();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1;
        checks++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1101) begin errors++;
            $display("FAIL lu_ctrl F/D/Db/Eb got=%b exp=1101", {F_stall, D_stall, D_bubble, E_bubble}); end
        next_cycle();
        idle();
        #1;
        checks++; if (lu_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", lu_cnt); end
        // popq matching srcB; RNONE destination must not trigger
        E_icode = 4'hB; E_dstM = 4'h6; d_srcB = 4'h6;
        #1;
        checks++; if (E_bubble !== 1'b1) begin errors++; $display("FAIL lu_popq_srcB got=%b exp=1", E_bubble); end
        E_dstM = 4'hF; d_srcB = 4'hF;
        #1;
        checks++; if ({F_stall, E_bubble} !== 2'b00) begin errors++;
            $display("FAIL lu_rnone got=%b exp=00", {F_stall, E_bubble}); end
        idle();
    endtask

    task automatic test_mispred();
        do_reset();
        E_icode = 4'h7; e_cnd = 1'b0;
        #1;
        checks++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b0011) begin errors++;
            $display("FAIL mp_ctrl F/D/Db/Eb got=%b exp=0011", {F_stall, D_stall, D_bubble, E_bubble}); end
        next_cycle();
        idle();
        #1;
        checks++; if (mp_cnt !== 4'd1) begin errors++; $display("FAIL mp_cnt got=%0d exp=1", mp_cnt); end
        E_icode = 4'h7; e_cnd = 1'b1;
        #1;
        checks++; if ({D_bubble, E_bubble} !== 2'b00) begin errors++;
            $display("FAIL mp_taken got=%b exp=00", {D_bubble, E_bubble}); end
        idle();
    endtask

    task automatic test_ret();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            if (i == 0) D_icode = 4'h9;
            if (i == 1) E_icode = 4'h9;
            if (i == 2) M_icode = 4'h9;
            #1;
            checks++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1010) begin errors++;
                $display("FAIL ret_ctrl stage=%0d got=%b exp=1010", i, {F_stall, D_stall, D_bubble, E_bubble}); end
            next_cycle();
        end
        idle();
        #1;
        checks++; if (ret_cnt !== 4'd3) begin errors++; $display("FAIL ret_cnt got=%0d exp=3", ret_cnt); end
        checks++; if (cyc_cnt !== 4'd3) begin errors++; $display("FAIL ret_cyc_cnt got=%0d exp=3", cyc_cnt); end
    endtask

    task automatic test_cc();
        do_reset();
        E_icode = 4'h6; alu_cf = 3'b010;
        #1;
        checks++; if (cc !== 3'b100) begin errors++; $display("FAIL cc_before_edge got=%b exp=100", cc); end
        next_cycle();
        E_icode = 4'h6; alu_cf = 3'b001; m_stat = 3'd3;
        #1;
        checks++; if (cc !== 3'b010) begin errors++; $display("FAIL cc_update got=%b exp=010", cc); end
        checks++; if (M_bubble !== 1'b1) begin errors++; $display("FAIL cc_m_bubble got=%b exp=1", M_bubble); end
        next_cycle();
        idle();
        #1;
        checks++; if (cc !== 3'b010) begin errors++; $display("FAIL cc_hold_sadr got=%b exp=010", cc); end
        alu_cf = 3'b111;
        next_cycle();
        checks++; if (cc !== 3'b010) begin errors++; $display("FAIL cc_hold_nonop got=%b exp=010", cc); end
    endtask

    task automatic test_mispred_ret();
        do_reset();
        E_icode = 4'h7; e_cnd = 1'b0; D_icode = 4'h9;
        #1;
        checks++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1011) begin errors++;
            $display("FAIL mp_ret_ctrl got=%b exp=1011", {F_stall, D_stall, D_bubble, E_bubble}); end
        next_cycle();
        idle();
        #1;
        checks++; if ({mp_cnt, ret_cnt} !== 8'h11) begin errors++;
            $display("FAIL mp_ret_cnts got=%h exp=11", {mp_cnt, ret_cnt}); end
        // load/use with ret in D: ret bubble suppressed, no ret count
        E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2; D_icode = 4'h9;
        #1;
        checks++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1101) begin errors++;
            $display("FAIL lu_ret_ctrl got=%b exp=1101", {F_stall, D_stall, D_bubble, E_bubble}); end
        next_cycle();
        idle();
        #1;
        checks++; if ({lu_cnt, ret_cnt} !== 8'h11) begin errors++;
            $display("FAIL lu_ret_cnts got=%h exp=11", {lu_cnt, ret_cnt}); end
    endtask

    task automatic test_saturate();
        do_reset();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        for (int i = 0; i < 15; i++) next_cycle();
        checks++; if (lu_cnt !== 4'hF) begin errors++; $display("FAIL sat_reach got=%h exp=f", lu_cnt); end
        next_cycle();
        checks++; if (lu_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got=%h exp=f", lu_cnt); end
        checks++; if (cyc_cnt !== 4'hF) begin errors++; $display("FAIL sat_cyc got=%h exp=f", cyc_cnt); end
        idle();
    endtask

    task automatic test_halt();
        do_reset();
        W_stat = 3'd2; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1;
        checks++; if ({halted, M_bubble, W_stall} !== 3'b011) begin errors++;
            $display("FAIL halt_pre got=%b exp=011", {halted, M_bubble, W_stall}); end
        next_cycle();
        W_stat = 3'd1;
        E_icode = 4'h7; e_cnd = 1'b0;
        #1;
        checks++; if ({halted, halt_stat} !== 4'b1010) begin errors++;
            $display("FAIL halt_entry halted/stat got=%b exp=1010", {halted, halt_stat}); end
        checks++; if ({F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall} !== 6'b110001) begin errors++;
            $display("FAIL halt_ctrl got=%b exp=110001", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}); end
        checks++; if ({cyc_cnt, lu_cnt, mp_cnt} !== 12'h110) begin errors++;
            $display("FAIL halt_entry_cnts got=%h exp=110", {cyc_cnt, lu_cnt, mp_cnt}); end
        next_cycle();
        E_icode = 4'h6; alu_cf = 3'b011;
        next_cycle();
        D_icode = 4'h9;
        next_cycle();
        checks++; if ({cyc_cnt, lu_cnt, mp_cnt, ret_cnt} !== 16'h1100) begin errors++;
            $display("FAIL halt_frozen_cnts got=%h exp=1100", {cyc_cnt, lu_cnt, mp_cnt, ret_cnt}); end
        checks++; if ({halted, cc} !== 4'b1100) begin errors++;
            $display("FAIL halt_cc_hold got=%b exp=1100", {halted, cc}); end
        // asynchronous reset mid-cycle while halted
        #2;
        idle();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        rst_n = 1'b0;
        #1;
        checks++; if ({halted, halt_stat, cc} !== 7'b0001100) begin errors++;
            $display("FAIL halt_rst got=%b exp=0001100", {halted, halt_stat, cc}); end
        checks++; if ({F_stall, D_stall, D_bubble, E_bubble, W_stall} !== 5'b11010) begin errors++;
            $display("FAIL halt_rst_ctrl got=%b exp=11010", {F_stall, D_stall, D_bubble, E_bubble, W_stall}); end
        checks++; if ({cyc_cnt, lu_cnt} !== 8'h00) begin errors++;
            $display("FAIL halt_rst_cnts got=%h exp=00", {cyc_cnt, lu_cnt}); end
        idle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_mispred();
        test_ret();
        test_cc();
        test_mispred_ret();
        test_saturate();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
